// File: rtl/alu_reservation_station_if.sv
// Dispatch / CDB / issue bundle for the ALU reservation station.
// master = producer/consumer side (dispatch unit, CDB, ALU); slave = the station.
interface alu_reservation_station_if #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 5
);
  logic                 flush;
  logic                 dispatch_valid;
  logic                 dispatch_ready;
  logic [2:0]           dispatch_funct3;
  logic                 dispatch_sign;
  logic                 dispatch_a_ready;
  logic                 dispatch_b_ready;
  logic [XLEN-1:0]      dispatch_a;
  logic [XLEN-1:0]      dispatch_b;
  logic [TAG_WIDTH-1:0] dispatch_a_tag;
  logic [TAG_WIDTH-1:0] dispatch_b_tag;
  logic [TAG_WIDTH-1:0] dispatch_dest_tag;
  logic                 cdb_valid;
  logic [TAG_WIDTH-1:0] cdb_tag;
  logic [XLEN-1:0]      cdb_value;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [XLEN-1:0]      issue_a;
  logic [XLEN-1:0]      issue_b;
  logic [2:0]           issue_funct3;
  logic                 issue_sign;
  logic [TAG_WIDTH-1:0] issue_dest_tag;

  modport master (
    output flush, dispatch_valid, dispatch_funct3, dispatch_sign,
           dispatch_a_ready, dispatch_b_ready, dispatch_a, dispatch_b,
           dispatch_a_tag, dispatch_b_tag, dispatch_dest_tag,
           cdb_valid, cdb_tag, cdb_value, issue_ready,
    input  dispatch_ready, issue_valid, issue_a, issue_b,
           issue_funct3, issue_sign, issue_dest_tag
  );

  modport slave (
    input  flush, dispatch_valid, dispatch_funct3, dispatch_sign,
           dispatch_a_ready, dispatch_b_ready, dispatch_a, dispatch_b,
           dispatch_a_tag, dispatch_b_tag, dispatch_dest_tag,
           cdb_valid, cdb_tag, cdb_value, issue_ready,
    output dispatch_ready, issue_valid, issue_a, issue_b,
           issue_funct3, issue_sign, issue_dest_tag
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands are
// present (direct, dispatch-time CDB bypass, or CDB snoop), then issues the
// lowest-index ready entry. Issue outputs depend on registered state only.

// One station slot. Top gates alloc with flush, so alloc never coincides with it.
module alu_rs_entry #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 alloc,
  input  logic                 release_en,
  input  logic [2:0]           d_funct3,
  input  logic                 d_sign,
  input  logic                 d_a_ready,
  input  logic                 d_b_ready,
  input  logic [XLEN-1:0]      d_a,
  input  logic [XLEN-1:0]      d_b,
  input  logic [TAG_WIDTH-1:0] d_a_tag,
  input  logic [TAG_WIDTH-1:0] d_b_tag,
  input  logic [TAG_WIDTH-1:0] d_dest_tag,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic [XLEN-1:0]      cdb_value,
  output logic                 busy,
  output logic                 ready,
  output logic [2:0]           funct3,
  output logic                 sign,
  output logic [TAG_WIDTH-1:0] dest_tag,
  output logic [XLEN-1:0]      a,
  output logic [XLEN-1:0]      b
);
  logic                 a_rdy, b_rdy;
  logic [TAG_WIDTH-1:0] a_tag, b_tag;
  logic                 a_byp, b_byp, a_hit, b_hit;

  // Same-cycle CDB result for an operand arriving with the dispatch.
  assign a_byp = !d_a_ready && cdb_valid && (cdb_tag == d_a_tag);
  assign b_byp = !d_b_ready && cdb_valid && (cdb_tag == d_b_tag);
  // Snoop for operands already parked in the slot.
  assign a_hit = busy && !a_rdy && cdb_valid && (cdb_tag == a_tag);
  assign b_hit = busy && !b_rdy && cdb_valid && (cdb_tag == b_tag);
  assign ready = busy && a_rdy && b_rdy;

  // Slot state: flush beats allocate beats release; operands fill on alloc or snoop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0; funct3 <= '0; sign <= 1'b0; dest_tag <= '0;
      a_rdy <= 1'b0; b_rdy <= 1'b0; a <= '0; b <= '0; a_tag <= '0; b_tag <= '0;
    end else begin
      if (flush)           busy <= 1'b0;
      else if (alloc)      busy <= 1'b1;
      else if (release_en) busy <= 1'b0;
      if (alloc) begin
        funct3   <= d_funct3;
        sign     <= d_sign;
        dest_tag <= d_dest_tag;
        a_tag    <= d_a_tag;
        b_tag    <= d_b_tag;
        a_rdy    <= d_a_ready | a_byp;
        b_rdy    <= d_b_ready | b_byp;
        a        <= d_a_ready ? d_a : (a_byp ? cdb_value : '0);
        b        <= d_b_ready ? d_b : (b_byp ? cdb_value : '0);
      end else begin
        if (a_hit) begin a_rdy <= 1'b1; a <= cdb_value; end
        if (b_hit) begin b_rdy <= 1'b1; b <= cdb_value; end
      end
    end
  end
endmodule

module alu_reservation_station #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 5,
  parameter int N_ENTRIES = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  alu_reservation_station_if.slave   bus
);
  logic [N_ENTRIES-1:0]                busy, rdy, alloc_oh, sel_oh;
  logic [N_ENTRIES-1:0][XLEN-1:0]      ent_a, ent_b;
  logic [N_ENTRIES-1:0][2:0]           ent_f3;
  logic [N_ENTRIES-1:0]                ent_sign;
  logic [N_ENTRIES-1:0][TAG_WIDTH-1:0] ent_dest;
  logic                                accept, fire;

  // Registered busy bits only: a slot freed this edge is not offered until next cycle.
  assign bus.dispatch_ready = ~&busy;
  assign accept             = bus.dispatch_valid & bus.dispatch_ready & ~bus.flush;
  assign bus.issue_valid    = |rdy;
  assign fire               = bus.issue_valid & bus.issue_ready;

  // Lowest-index free slot and lowest-index ready slot (descending scan, last write wins).
  always_comb begin
    alloc_oh = '0;
    sel_oh   = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) begin alloc_oh = '0; alloc_oh[i] = 1'b1; end
      if (rdy[i])   begin sel_oh   = '0; sel_oh[i]   = 1'b1; end
    end
  end

  for (genvar g = 0; g < N_ENTRIES; g++) begin : g_ent
    alu_rs_entry #(.XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH)) u_ent (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (bus.flush),
      .alloc      (accept & alloc_oh[g]),
      .release_en (fire & sel_oh[g]),
      .d_funct3   (bus.dispatch_funct3),
      .d_sign     (bus.dispatch_sign),
      .d_a_ready  (bus.dispatch_a_ready),
      .d_b_ready  (bus.dispatch_b_ready),
      .d_a        (bus.dispatch_a),
      .d_b        (bus.dispatch_b),
      .d_a_tag    (bus.dispatch_a_tag),
      .d_b_tag    (bus.dispatch_b_tag),
      .d_dest_tag (bus.dispatch_dest_tag),
      .cdb_valid  (bus.cdb_valid),
      .cdb_tag    (bus.cdb_tag),
      .cdb_value  (bus.cdb_value),
      .busy       (busy[g]),
      .ready      (rdy[g]),
      .funct3     (ent_f3[g]),
      .sign       (ent_sign[g]),
      .dest_tag   (ent_dest[g]),
      .a          (ent_a[g]),
      .b          (ent_b[g])
    );
  end

  // AND-OR mux of the selected slot; all-zero when nothing is ready.
  always_comb begin
    bus.issue_a        = '0;
    bus.issue_b        = '0;
    bus.issue_funct3   = '0;
    bus.issue_sign     = 1'b0;
    bus.issue_dest_tag = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      bus.issue_a        = bus.issue_a        | (ent_a[i]    & {XLEN{sel_oh[i]}});
      bus.issue_b        = bus.issue_b        | (ent_b[i]    & {XLEN{sel_oh[i]}});
      bus.issue_funct3   = bus.issue_funct3   | (ent_f3[i]   & {3{sel_oh[i]}});
      bus.issue_sign     = bus.issue_sign     | (ent_sign[i] & sel_oh[i]);
      bus.issue_dest_tag = bus.issue_dest_tag | (ent_dest[i] & {TAG_WIDTH{sel_oh[i]}});
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios plus randomized
// traffic, all checked against a slot-array reference model.
module tb_alu_reservation_station;
  localparam int XLEN = 32;
  localparam int TW   = 5;
  localparam int N    = 4;
  localparam int VW   = 2 + 3 + 1 + TW + 2 * XLEN;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_reservation_station_if #(.XLEN(XLEN), .TAG_WIDTH(TW)) ifc ();
  alu_reservation_station #(.XLEN(XLEN), .TAG_WIDTH(TW), .N_ENTRIES(N)) dut (
    .clk(clk), .reset_n(reset_n), .bus(ifc)
  );

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    bit          busy;
    bit [2:0]    f3;
    bit          sg;
    bit [TW-1:0] dst;
    bit          ar, br;
    bit [XLEN-1:0] a, b;
    bit [TW-1:0] at, bt;
  } ent_t;
  ent_t m[N];

  wire [VW-1:0] dut_vec = {ifc.dispatch_ready, ifc.issue_valid, ifc.issue_funct3,
                           ifc.issue_sign, ifc.issue_dest_tag, ifc.issue_a, ifc.issue_b};

  function automatic int m_free();
    for (int i = 0; i < N; i++) if (!m[i].busy) return i;
    return -1;
  endfunction

  function automatic int m_sel();
    for (int i = 0; i < N; i++) if (m[i].busy && m[i].ar && m[i].br) return i;
    return -1;
  endfunction

  // Expected outputs from the model's current contents.
  function automatic logic [VW-1:0] m_exp();
    int s = m_sel();
    logic dr = (m_free() >= 0);
    if (s < 0) return {dr, 1'b0, {(VW-2){1'b0}}};
    return {dr, 1'b1, m[s].f3, m[s].sg, m[s].dst, m[s].a, m[s].b};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m[i] = '{default: '0};
  endtask

  // Apply one clock edge worth of behaviour using the inputs currently driven.
  task automatic m_step();
    int s = m_sel();
    int f = m_free();
    if (ifc.flush) begin
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++) if (m[i].busy && ifc.cdb_valid) begin
      if (!m[i].ar && m[i].at == ifc.cdb_tag) begin m[i].ar = 1; m[i].a = ifc.cdb_value; end
      if (!m[i].br && m[i].bt == ifc.cdb_tag) begin m[i].br = 1; m[i].b = ifc.cdb_value; end
    end
    if (s >= 0 && ifc.issue_ready) m[s].busy = 1'b0;
    if (ifc.dispatch_valid && f >= 0) begin
      m[f].busy = 1; m[f].f3 = ifc.dispatch_funct3; m[f].sg = ifc.dispatch_sign;
      m[f].dst = ifc.dispatch_dest_tag; m[f].at = ifc.dispatch_a_tag; m[f].bt = ifc.dispatch_b_tag;
      m[f].ar = ifc.dispatch_a_ready || (ifc.cdb_valid && ifc.cdb_tag == ifc.dispatch_a_tag);
      m[f].br = ifc.dispatch_b_ready || (ifc.cdb_valid && ifc.cdb_tag == ifc.dispatch_b_tag);
      m[f].a  = ifc.dispatch_a_ready ? ifc.dispatch_a : ifc.cdb_value;
      m[f].b  = ifc.dispatch_b_ready ? ifc.dispatch_b : ifc.cdb_value;
    end
  endtask

  task automatic adv();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ir);
    ifc.flush = 0; ifc.dispatch_valid = 0; ifc.dispatch_funct3 = 0; ifc.dispatch_sign = 0;
    ifc.dispatch_a_ready = 0; ifc.dispatch_b_ready = 0; ifc.dispatch_a = 0; ifc.dispatch_b = 0;
    ifc.dispatch_a_tag = 0; ifc.dispatch_b_tag = 0; ifc.dispatch_dest_tag = 0;
    ifc.cdb_valid = 0; ifc.cdb_tag = 0; ifc.cdb_value = 0; ifc.issue_ready = ir;
  endtask

  task automatic disp(input bit [2:0] f3, input bit sg, input bit ar, input bit [XLEN-1:0] a,
                      input bit [TW-1:0] at, input bit br, input bit [XLEN-1:0] b,
                      input bit [TW-1:0] bt, input bit [TW-1:0] dst);
    ifc.dispatch_valid = 1; ifc.dispatch_funct3 = f3; ifc.dispatch_sign = sg;
    ifc.dispatch_a_ready = ar; ifc.dispatch_a = a; ifc.dispatch_a_tag = at;
    ifc.dispatch_b_ready = br; ifc.dispatch_b = b; ifc.dispatch_b_tag = bt;
    ifc.dispatch_dest_tag = dst;
  endtask

  task automatic test_reset();
    idle(0);
    reset_n = 0;
    m_reset();
    #1;
    n_cmp++; if (ifc.dispatch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_dr got=%b want=1", ifc.dispatch_ready); end
    n_cmp++; if (ifc.issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iv got=%b want=0", ifc.issue_valid); end
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    // three busy entries, then asynchronous reset in the middle of a cycle
    for (int k = 0; k < 3; k++) begin
      idle(0); disp(3'(k), 1, 1, 32'h100 + k, 0, 1, 32'h200, 0, 5'(k + 1));
      @(negedge clk);
      n_cmp++; if (dut_vec !== m_exp()) begin n_fail++; $display("FAIL reset_fill k=%0d got=%h want=%h", k, dut_vec, m_exp()); end
      adv();
    end
    idle(0);
    #2;
    n_cmp++; if (ifc.issue_valid !== 1'b1) begin n_fail++; $display("FAIL reset_pre_iv got=%b want=1", ifc.issue_valid); end
    reset_n = 0;
    m_reset();
    #1;
    n_cmp++; if (ifc.dispatch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_dr got=%b want=1", ifc.dispatch_ready); end
    n_cmp++; if (ifc.issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_iv got=%b want=0", ifc.issue_valid); end
    n_cmp++; if (ifc.issue_a !== '0) begin n_fail++; $display("FAIL reset_mid_a got=%h want=0", ifc.issue_a); end
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    idle(1); disp(3'b000, 1, 1, 10, 0, 1, 3, 0, 9);
    @(negedge clk);
    n_cmp++; if (ifc.issue_valid !== 1'b0) begin n_fail++; $display("FAIL basic_t0_iv got=%b want=0", ifc.issue_valid); end
    adv();
    idle(1);
    @(negedge clk);
    n_cmp++; if ({ifc.issue_valid, ifc.issue_a, ifc.issue_b, ifc.issue_sign, ifc.issue_funct3, ifc.issue_dest_tag} !== {1'b1, 32'd10, 32'd3, 1'b1, 3'b000, 5'd9})
      begin n_fail++; $display("FAIL basic_t1 got iv=%b a=%0d b=%0d s=%b f3=%0d d=%0d want 1/10/3/1/0/9", ifc.issue_valid, ifc.issue_a, ifc.issue_b, ifc.issue_sign, ifc.issue_funct3, ifc.issue_dest_tag); end
    n_cmp++; if (dut_vec !== m_exp()) begin n_fail++; $display("FAIL basic_model got=%h want=%h", dut_vec, m_exp()); end
    adv();
    @(negedge clk);
    n_cmp++; if (ifc.issue_valid !== 1'b0) begin n_fail++; $display("FAIL basic_t2_iv got=%b want=0", ifc.issue_valid); end
    adv();
  endtask

  task automatic test_wakeup();
    // cycles 0..4: dispatch waiting on tag 7, broadcast at cycle 3, issue at 4
    for (int k = 0; k <= 4; k++) begin
      idle(1);
      if (k == 0) disp(3'b010, 0, 0, 0, 7, 1, 4, 0, 3);
      if (k == 3) begin ifc.cdb_valid = 1; ifc.cdb_tag = 7; ifc.cdb_value = 32'h55; end
      @(negedge clk);
      n_cmp++; if (ifc.issue_valid !== (k == 4)) begin n_fail++; $display("FAIL wake_iv k=%0d got=%b want=%b", k, ifc.issue_valid, k == 4); end
      if (k == 4) begin
        n_cmp++; if (ifc.issue_a !== 32'h55) begin n_fail++; $display("FAIL wake_a got=%h want=55", ifc.issue_a); end
      end
      adv();
    end
    // bypass: broadcast in the dispatch cycle itself
    idle(1); disp(3'b100, 0, 0, 0, 7, 1, 5, 0, 4);
    ifc.cdb_valid = 1; ifc.cdb_tag = 7; ifc.cdb_value = 32'h66;
    @(negedge clk);
    n_cmp++; if (ifc.issue_valid !== 1'b0) begin n_fail++; $display("FAIL byp_t0_iv got=%b want=0", ifc.issue_valid); end
    adv();
    idle(1);
    @(negedge clk);
    n_cmp++; if ({ifc.issue_valid, ifc.issue_a, ifc.issue_dest_tag} !== {1'b1, 32'h66, 5'd4})
      begin n_fail++; $display("FAIL byp_t1 got iv=%b a=%h d=%0d want 1/66/4", ifc.issue_valid, ifc.issue_a, ifc.issue_dest_tag); end
    adv();
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      idle(0); disp(3'(k), 0, 1, 32'(k), 0, 1, 32'(k * 2), 0, 5'(16 + k));
      @(negedge clk);
      n_cmp++; if (ifc.dispatch_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill_dr k=%0d got=%b want=1", k, ifc.dispatch_ready); end
      adv();
    end
    idle(0); disp(3'b111, 1, 1, 99, 0, 1, 99, 0, 20);
    @(negedge clk);
    n_cmp++; if (ifc.dispatch_ready !== 1'b0) begin n_fail++; $display("FAIL full_dr got=%b want=0", ifc.dispatch_ready); end
    adv();
    idle(1);
    @(negedge clk);
    n_cmp++; if ({ifc.issue_valid, ifc.issue_dest_tag, ifc.dispatch_ready} !== {1'b1, 5'd16, 1'b0})
      begin n_fail++; $display("FAIL full_rel got iv=%b d=%0d dr=%b want 1/16/0", ifc.issue_valid, ifc.issue_dest_tag, ifc.dispatch_ready); end
    adv();
    idle(0);
    @(negedge clk);
    n_cmp++; if (ifc.dispatch_ready !== 1'b1) begin n_fail++; $display("FAIL full_freed_dr got=%b want=1", ifc.dispatch_ready); end
    adv();
    for (int k = 0; k < 3; k++) begin
      idle(1);
      @(negedge clk);
      n_cmp++; if (ifc.issue_dest_tag !== 5'(17 + k)) begin n_fail++; $display("FAIL full_drain k=%0d got=%0d want=%0d", k, ifc.issue_dest_tag, 17 + k); end
      adv();
    end
    @(negedge clk);
    n_cmp++; if (ifc.issue_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty_iv got=%b want=0", ifc.issue_valid); end
    idle(0);
    adv();
  endtask

  task automatic test_priority();
    // slot0 waits tag2, slot1 waits tag6 on both operands, slot2 waits tag4
    bit          exp_iv[6]  = '{0, 1, 1, 1, 0, 1};
    bit [TW-1:0] exp_dst[6] = '{0, 12, 10, 12, 0, 11};
    idle(0); disp(0, 0, 0, 0, 2, 1, 1, 0, 10); @(negedge clk); adv();
    idle(0); disp(0, 0, 0, 0, 6, 0, 0, 6, 11); @(negedge clk); adv();
    idle(0); disp(0, 0, 0, 0, 4, 1, 2, 0, 12); @(negedge clk); adv();
    for (int k = 0; k < 6; k++) begin
      idle(k >= 2);
      if (k == 0) begin ifc.cdb_valid = 1; ifc.cdb_tag = 4; ifc.cdb_value = 32'h44; end
      if (k == 1) begin ifc.cdb_valid = 1; ifc.cdb_tag = 2; ifc.cdb_value = 32'h22; end
      if (k == 4) begin ifc.cdb_valid = 1; ifc.cdb_tag = 6; ifc.cdb_value = 32'h77; end
      @(negedge clk);
      n_cmp++; if ({ifc.issue_valid, ifc.issue_dest_tag} !== {exp_iv[k], exp_iv[k] ? exp_dst[k] : 5'd0})
        begin n_fail++; $display("FAIL prio k=%0d got iv=%b d=%0d want %b/%0d", k, ifc.issue_valid, ifc.issue_dest_tag, exp_iv[k], exp_dst[k]); end
      if (k == 5) begin
        n_cmp++; if ({ifc.issue_a, ifc.issue_b} !== {32'h77, 32'h77}) begin n_fail++; $display("FAIL prio_shared got a=%h b=%h want 77/77", ifc.issue_a, ifc.issue_b); end
      end
      n_cmp++; if (dut_vec !== m_exp()) begin n_fail++; $display("FAIL prio_model k=%0d got=%h want=%h", k, dut_vec, m_exp()); end
      adv();
    end
  endtask

  task automatic test_flush();
    idle(0); disp(1, 0, 1, 5, 0, 1, 6, 0, 21); @(negedge clk); adv();
    idle(0); disp(2, 0, 1, 7, 0, 1, 8, 0, 22); @(negedge clk); adv();
    idle(1); disp(3, 0, 1, 9, 0, 1, 9, 0, 25); ifc.flush = 1;
    @(negedge clk);
    n_cmp++; if (ifc.issue_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_iv got=%b want=1", ifc.issue_valid); end
    adv();
    for (int k = 0; k < 3; k++) begin
      idle(1);
      @(negedge clk);
      n_cmp++; if ({ifc.dispatch_ready, ifc.issue_valid, ifc.issue_a} !== {1'b1, 1'b0, 32'd0})
        begin n_fail++; $display("FAIL flush_after k=%0d got dr=%b iv=%b a=%h want 1/0/0", k, ifc.dispatch_ready, ifc.issue_valid, ifc.issue_a); end
      adv();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      idle($urandom_range(0, 9) < 6);
      ifc.flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) < 6)
        disp(3'($urandom), 1'($urandom), 1'($urandom), $urandom, 5'($urandom_range(0, 7)),
             1'($urandom), $urandom, 5'($urandom_range(0, 7)), 5'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        ifc.cdb_valid = 1; ifc.cdb_tag = 5'($urandom_range(0, 7)); ifc.cdb_value = $urandom;
      end
      @(negedge clk);
      n_cmp++; if (dut_vec !== m_exp()) begin n_fail++; $display("FAIL rand k=%0d got=%h want=%h", k, dut_vec, m_exp()); end
      adv();
    end
    idle(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_full();
    test_priority();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Out-of-order backend reservation station that feeds the integer ALU. It holds dispatched ALU operations until both source operands are available, snoops the common data bus (CDB) for results, and issues one ready operation per cycle. It drives the ALU operand, funct3 and sign inputs plus the destination ROB tag carried alongside the result.

## Interface
Parameters:
- XLEN, 32, operand width
- TAG_WIDTH, 5, ROB tag width
- N_ENTRIES, 4, station depth (≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries (mispredict)
- dispatch_valid  in  1  dispatch request
- dispatch_ready  out  1  at least one free entry
- dispatch_funct3  in  3  ALU funct3
- dispatch_sign  in  1  ALU sub/arith-shift control
- dispatch_a_ready / dispatch_b_ready  in  1  operand value valid
- dispatch_a / dispatch_b  in  XLEN  operand value (ignored if not ready)
- dispatch_a_tag / dispatch_b_tag  in  TAG_WIDTH  producer tag when not ready
- dispatch_dest_tag  in  TAG_WIDTH  ROB tag of this op
- cdb_valid  in  1  CDB broadcast
- cdb_tag  in  TAG_WIDTH  broadcast producer tag
- cdb_value  in  XLEN  broadcast result
- issue_valid  out  1  an entry is issuing
- issue_ready  in  1  ALU accepts
- issue_a / issue_b  out  XLEN  ALU operands
- issue_funct3  out  3;  issue_sign  out  1
- issue_dest_tag  out  TAG_WIDTH

## Operation
- Entry state: busy, funct3, sign, dest_tag, and per operand {ready, value, tag}.
- dispatch_ready = any entry !busy, computed from registered busy bits only. An entry freed this cycle is not reusable until next cycle.
- Dispatch accepted on dispatch_valid & dispatch_ready: write the lowest-index free entry and set busy.
- Dispatch-time bypass: if an operand is not ready and cdb_valid & cdb_tag == operand tag in the same cycle, the entry stores cdb_value with ready=1.
- Snoop: every cycle, each busy entry operand with ready=0 and tag == cdb_tag (cdb_valid=1) captures cdb_value and sets ready. Both operands may capture from the same broadcast.
- Issue select: lowest-index entry with busy & a.ready & b.ready, using registered state only. issue_valid is asserted if any such entry exists.
- issue_* outputs are combinational muxes of the selected entry. When issue_valid=0 they are 0.
- On issue_valid & issue_ready the selected entry clears busy at the edge. issue_valid may stay high for another entry next cycle.
- Stall: while issue_ready=0, the selection and outputs stay stable unless a lower-index entry becomes ready (allowed, no lock-in).
- flush=1: all busy bits clear at the edge. Flush has priority over same-cycle dispatch (dropped) and issue (handshake discarded, consumer ignores).
- Reset: all busy=0, all stored fields 0. Hence dispatch_ready=1, issue_valid=0, issue data 0.
- Full (all busy): dispatch_ready=0 and dispatch_valid is ignored. Simultaneous issue does not open a slot the same cycle.

## Timing
- Dispatch with both operands ready at t: issue_valid earliest t+1.
- CDB broadcast at t satisfying the last operand (snoop or bypass): issue_valid earliest t+1.
- Throughput: 1 dispatch and 1 issue per cycle.
- Issue-to-free latency: 1 edge. Freed slot is visible on dispatch_ready the next cycle.
- No combinational path from dispatch_* or cdb_* to issue_*. issue_ready affects only state.

## Test plan
- Reset mid-operation with 3 busy entries, reset_n low → dispatch_ready=1, issue_valid=0, issue_a=0 immediately (async).
- Dispatch funct3=000, sign=1, a=10, b=3, both ready at t, issue_ready=1 → t+1: issue_valid=1, issue_a=10, issue_b=3, issue_sign=1, matching dest_tag; t+2: issue_valid=0.
- Dispatch with a waiting on tag 7; CDB tag 7 value 0x55 at t+3 → issue_valid first at t+4 with issue_a=0x55. Repeat with CDB tag 7 in the dispatch cycle → issue at dispatch+1.
- Fill 4 entries with issue_ready=0 → dispatch_ready=0 and a 5th dispatch is dropped. Release one entry → dispatch_ready=1 the cycle after the handshake.
- Entries 2 and 0 both become ready → entry 0 issues first, then entry 2. A shared CDB tag wakes both operands of one entry in one cycle.
- flush with dispatch_valid=1 and a pending issue handshake → next cycle all free, issue_valid=0, dispatched op absent.
